// File: rtl/bm_pkg.sv
// Shared types and helpers for the block-matching disparity detector.
// Optional feature macro used elsewhere in this slice: BM_DET_MASK_EN.
package bm_pkg;

    localparam int SAD_W    = 16;
    localparam int IDX_W    = 5;
    localparam int LANES    = 8;
    localparam int BEATS    = 4;
    localparam int NUM_CAND = 32;
    localparam int LANE_W   = $clog2(LANES);
    localparam int BEAT_W   = $clog2(BEATS);

    typedef struct packed {
        logic [SAD_W-1:0] min1;
        logic [IDX_W-1:0] idx1;
        logic [SAD_W-1:0] min2;
        logic [IDX_W-1:0] idx2;
    } bm_top2_t;

    // Lexicographic {SAD, index} compare: a SAD tie goes to the lower index.
    function automatic logic key_lt(input logic [SAD_W-1:0] a_sad, input logic [IDX_W-1:0] a_idx,
                                    input logic [SAD_W-1:0] b_sad, input logic [IDX_W-1:0] b_idx);
        return {a_sad, a_idx} < {b_sad, b_idx};
    endfunction

endpackage

// File: rtl/bm_calc_det_if.sv
// SAD beat stream in, top-2 detection result out.
// BM_DET_MASK_EN adds the per-lane sad_mask signal.
interface bm_calc_det_if;
    import bm_pkg::*;

    logic                   sad_vld;
    logic                   sad_sop;
    logic [LANES*SAD_W-1:0] sad_in;
`ifdef BM_DET_MASK_EN
    logic [LANES-1:0]       sad_mask;
`endif
    logic [SAD_W-1:0]       det_min1;
    logic [SAD_W-1:0]       det_min2;
    logic [IDX_W-1:0]       det_idx1;
    logic [IDX_W-1:0]       det_idx2;
    logic                   vout_m1;
    logic                   err_proto;

`ifdef BM_DET_MASK_EN
    modport master (output sad_vld, sad_sop, sad_in, sad_mask,
                    input  det_min1, det_min2, det_idx1, det_idx2, vout_m1, err_proto);
    modport slave  (input  sad_vld, sad_sop, sad_in, sad_mask,
                    output det_min1, det_min2, det_idx1, det_idx2, vout_m1, err_proto);
`else
    modport master (output sad_vld, sad_sop, sad_in,
                    input  det_min1, det_min2, det_idx1, det_idx2, vout_m1, err_proto);
    modport slave  (input  sad_vld, sad_sop, sad_in,
                    output det_min1, det_min2, det_idx1, det_idx2, vout_m1, err_proto);
`endif

endinterface

// File: rtl/bm_det_top2_merge.sv
// Combinational merge of two sorted top-2 pairs into one; equal keys favour input a.
// Not affected by BM_DET_MASK_EN.
module bm_det_top2_merge
    import bm_pkg::*;
(
    input  bm_top2_t a_i,
    input  bm_top2_t b_i,
    output bm_top2_t y_o
);

    // Pick the overall winner, then the runner-up among the loser's head and the winner's tail.
    always_comb begin
        y_o = a_i;
        if (!key_lt(b_i.min1, b_i.idx1, a_i.min1, a_i.idx1)) begin
            y_o.min1 = a_i.min1;
            y_o.idx1 = a_i.idx1;
            if (key_lt(b_i.min1, b_i.idx1, a_i.min2, a_i.idx2)) begin
                y_o.min2 = b_i.min1;
                y_o.idx2 = b_i.idx1;
            end else begin
                y_o.min2 = a_i.min2;
                y_o.idx2 = a_i.idx2;
            end
        end else begin
            y_o.min1 = b_i.min1;
            y_o.idx1 = b_i.idx1;
            if (key_lt(b_i.min2, b_i.idx2, a_i.min1, a_i.idx1)) begin
                y_o.min2 = b_i.min2;
                y_o.idx2 = b_i.idx2;
            end else begin
                y_o.min2 = a_i.min1;
                y_o.idx2 = a_i.idx1;
            end
        end
    end

endmodule

// File: rtl/bm_calc_det.sv
// Per-pixel top-2 SAD detector: stage A reduces one beat, stage B folds beats into a pixel result.
// Optional BM_DET_MASK_EN: masked lanes are forced to all-ones SAD before the tree.
module bm_calc_det
    import bm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    bm_calc_det_if.slave  bus
);

    // A lone leaf has no real runner-up; this sentinel is the largest possible key.
    localparam logic [IDX_W-1:0] SENT_IDX = IDX_W'(NUM_CAND - 1);

    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_idx;
    logic              acc;
    logic              err_d, err_q;

    logic              a_vld_q;
    logic              a_last_q;
    logic [BEAT_W-1:0] a_beat_q;
    bm_top2_t          a_top_q;

    bm_top2_t          run_q, run_d, merged;
    bm_top2_t          det_q;

    bm_top2_t          lvl0 [LANES];
    bm_top2_t          lvl1 [LANES/2];
    bm_top2_t          lvl2 [LANES/4];
    bm_top2_t          lvl3 [LANES/8];

    // Beat acceptance and protocol checking against the beat counter.
    always_comb begin
        acc      = 1'b0;
        beat_idx = cnt_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        if (bus.sad_vld) begin
            if (bus.sad_sop) begin
                acc      = 1'b1;
                beat_idx = '0;
                cnt_d    = BEAT_W'(1);
                err_d    = (cnt_q != '0);
            end else if (cnt_q == '0) begin
                err_d    = 1'b1;
            end else begin
                acc      = 1'b1;
                cnt_d    = (cnt_q == BEAT_W'(BEATS-1)) ? '0 : cnt_q + BEAT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_leaf
        logic [SAD_W-1:0] sad_k;
`ifdef BM_DET_MASK_EN
        assign sad_k = bus.sad_mask[k] ? {SAD_W{1'b1}} : bus.sad_in[k*SAD_W +: SAD_W];
`else
        assign sad_k = bus.sad_in[k*SAD_W +: SAD_W];
`endif
        assign lvl0[k] = '{min1: sad_k, idx1: {beat_idx, LANE_W'(k)},
                           min2: {SAD_W{1'b1}}, idx2: SENT_IDX};
    end

    for (genvar n = 0; n < LANES/2; n++) begin : g_l1
        bm_det_top2_merge u_m (.a_i(lvl0[2*n]), .b_i(lvl0[2*n+1]), .y_o(lvl1[n]));
    end

    for (genvar n = 0; n < LANES/4; n++) begin : g_l2
        bm_det_top2_merge u_m (.a_i(lvl1[2*n]), .b_i(lvl1[2*n+1]), .y_o(lvl2[n]));
    end

    for (genvar n = 0; n < LANES/8; n++) begin : g_l3
        bm_det_top2_merge u_m (.a_i(lvl2[2*n]), .b_i(lvl2[2*n+1]), .y_o(lvl3[n]));
    end

    // Counter, error pulse and stage-A registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            err_q    <= 1'b0;
            a_vld_q  <= 1'b0;
            a_last_q <= 1'b0;
            a_beat_q <= '0;
            a_top_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            a_vld_q <= acc;
            if (acc) begin
                a_top_q  <= lvl3[0];
                a_beat_q <= beat_idx;
                a_last_q <= (beat_idx == BEAT_W'(BEATS-1));
            end
        end
    end

    bm_det_top2_merge u_stage_b (.a_i(run_q), .b_i(a_top_q), .y_o(merged));

    // The first beat of a pixel restarts the running pair instead of merging into stale state.
    always_comb begin
        run_d = (a_beat_q == '0) ? a_top_q : merged;
    end

    // Stage-B running state and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
            det_q <= '0;
        end else if (a_vld_q) begin
            run_q <= run_d;
            if (a_last_q) begin
                det_q <= run_d;
            end
        end
    end

    assign bus.det_min1  = det_q.min1;
    assign bus.det_idx1  = det_q.idx1;
    assign bus.det_min2  = det_q.min2;
    assign bus.det_idx2  = det_q.idx2;
    assign bus.vout_m1   = a_vld_q & a_last_q;
    assign bus.err_proto = err_q;

endmodule
